// File: rtl/dunc_pkg.sv
// Shared opcode, phase and decode definitions for the dunc_core accumulator CPU.
package dunc_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_STA = 4'h2,
        OP_ADD = 4'h3,
        OP_SUB = 4'h4,
        OP_AND = 4'h5,
        OP_JMP = 4'h6,
        OP_JZ  = 4'h7,
        OP_JN  = 4'h8,
        OP_HLT = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        PH_0 = 2'd0,
        PH_1 = 2'd1,
        PH_2 = 2'd2,
        PH_3 = 2'd3
    } phase_e;

    localparam logic [3:0] PH_T0 = 4'b0001;
    localparam logic [3:0] PH_T1 = 4'b0010;
    localparam logic [3:0] PH_T2 = 4'b0100;
    localparam logic [3:0] PH_T3 = 4'b1000;

    // Memory-class opcodes take an EXECUTE cycle after FETCH.
    function automatic logic is_mem_op(input logic [3:0] op);
        return op <= OP_AND;
    endfunction

    function automatic logic is_rd_op(input logic [3:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
    endfunction

endpackage

// File: rtl/dunc_tstate.sv
// Four-phase T0-T3 generator with wait-state stall and halt freeze.
module dunc_tstate
    import dunc_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic stall,
    input  logic freeze,
    output logic t0,
    output logic t1,
    output logic t2,
    output logic t3
);

    phase_e     phase;
    phase_e     phase_next;
    logic [3:0] onehot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) phase <= PH_0;
        else     phase <= phase_next;
    end

    always_comb begin
        phase_next = phase;
        onehot     = PH_T0;
        if (!stall && !freeze) begin
            case (phase)
                PH_0:    phase_next = PH_1;
                PH_1:    phase_next = PH_2;
                PH_2:    phase_next = PH_3;
                default: phase_next = PH_0;
            endcase
        end
        case (phase)
            PH_0:    onehot = PH_T0;
            PH_1:    onehot = PH_T1;
            PH_2:    onehot = PH_T2;
            default: onehot = PH_T3;
        endcase
    end

    assign {t3, t2, t1, t0} = onehot;

endmodule

// File: rtl/dunc_core.sv
// Parametrised single-accumulator CPU: FETCH/EXECUTE sequencing, registers, decode and ALU.
module dunc_core
    import dunc_pkg::*;
#(
    parameter int unsigned         DATA_W   = 16,
    parameter int unsigned         ADDR_W   = 12,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] MEM_RDATA,
    input  logic              MEM_READY,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    output logic              MEM_RD,
    output logic              MEM_WE,
    output logic              T0,
    output logic              T1,
    output logic              T2,
    output logic              T3,
    output logic              FETCH,
    output logic              EXECUTE,
    output logic [ADDR_W-1:0] PC_OUT,
    output logic [ADDR_W-1:0] MA_OUT,
    output logic [DATA_W-1:0] MD_OUT,
    output logic [DATA_W-1:0] AC_OUT,
    output logic [3:0]        IR_OUT,
    output logic              HALTED
);

    logic              fetch;
    logic              halted;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] ma;
    logic [DATA_W-1:0] md;
    logic [DATA_W-1:0] ac;
    logic [3:0]        ir;
    logic              t0, t1, t2, t3;
    logic              rd, we, stall, take_jump;
    logic [DATA_W-1:0] alu;

    // Strobes come only from registered state so MEM_READY never reaches them.
    assign rd    = t1 && !halted && (fetch || is_rd_op(ir));
    assign we    = t1 && !halted && !fetch && (ir == OP_STA);
    assign stall = (rd || we) && !MEM_READY;

    dunc_tstate u_tstate (
        .clk    (CLK),
        .rst    (RESET),
        .stall  (stall),
        .freeze (halted),
        .t0     (t0),
        .t1     (t1),
        .t2     (t2),
        .t3     (t3)
    );

    always_comb begin
        take_jump = 1'b0;
        case (ir)
            OP_JMP:  take_jump = 1'b1;
            OP_JZ:   take_jump = (ac == '0);
            OP_JN:   take_jump = ac[DATA_W-1];
            default: take_jump = 1'b0;
        endcase
    end

    always_comb begin
        alu = ac;
        case (ir)
            OP_LDA:  alu = md;
            OP_ADD:  alu = ac + md;
            OP_SUB:  alu = ac - md;
            OP_AND:  alu = ac & md;
            default: alu = ac;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            fetch  <= 1'b1;
            halted <= 1'b0;
            pc     <= RESET_PC;
            ma     <= '0;
            md     <= '0;
            ac     <= '0;
            ir     <= '0;
        end else if (!halted) begin
            if (fetch) begin
                if (t0) ma <= pc;
                if (t1 && !stall) md <= MEM_RDATA;
                if (t2) begin
                    ir <= md[DATA_W-1 -: 4];
                    ma <= md[ADDR_W-1:0];
                    pc <= pc + ADDR_W'(1);
                end
                if (t3) begin
                    if (is_mem_op(ir)) begin
                        fetch <= 1'b0;
                    end else begin
                        if (take_jump)     pc     <= ma;
                        if (ir == OP_HLT)  halted <= 1'b1;
                    end
                end
            end else begin
                if (t0 && (ir == OP_STA))          md    <= ac;
                if (t1 && !stall && is_rd_op(ir))  md    <= MEM_RDATA;
                if (t2)                            ac    <= alu;
                if (t3)                            fetch <= 1'b1;
            end
        end
    end

    assign MEM_ADDR  = ma;
    assign MEM_WDATA = md;
    assign MEM_RD    = rd;
    assign MEM_WE    = we;
    assign T0        = t0;
    assign T1        = t1;
    assign T2        = t2;
    assign T3        = t3;
    assign FETCH     = fetch;
    assign EXECUTE   = !fetch;
    assign PC_OUT    = pc;
    assign MA_OUT    = ma;
    assign MD_OUT    = md;
    assign AC_OUT    = ac;
    assign IR_OUT    = ir;
    assign HALTED    = halted;

endmodule

// File: tb/tb_dunc_core.sv
// Self-checking bench for dunc_core against an instruction-level reference model.
module tb_dunc_core;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] MEM_RDATA;
    logic        MEM_READY;
    logic [11:0] MEM_ADDR;
    logic [15:0] MEM_WDATA;
    logic        MEM_RD, MEM_WE;
    logic        T0, T1, T2, T3, FETCH, EXECUTE;
    logic [11:0] PC_OUT, MA_OUT;
    logic [15:0] MD_OUT, AC_OUT;
    logic [3:0]  IR_OUT;
    logic        HALTED;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem     [0:4095];
    logic [15:0] ref_mem [0:4095];
    logic [15:0] ref_ac;
    logic [11:0] ref_pc;
    int unsigned ref_clocks;

    dunc_core #(.DATA_W(16), .ADDR_W(12), .RESET_PC(12'h000)) dut (
        .CLK(CLK), .RESET(RESET), .MEM_RDATA(MEM_RDATA), .MEM_READY(MEM_READY),
        .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_RD(MEM_RD), .MEM_WE(MEM_WE),
        .T0(T0), .T1(T1), .T2(T2), .T3(T3), .FETCH(FETCH), .EXECUTE(EXECUTE),
        .PC_OUT(PC_OUT), .MA_OUT(MA_OUT), .MD_OUT(MD_OUT), .AC_OUT(AC_OUT),
        .IR_OUT(IR_OUT), .HALTED(HALTED)
    );

    always #5 CLK = ~CLK;

    assign MEM_RDATA = mem[MEM_ADDR];

    always @(posedge CLK) begin
        if (MEM_WE && MEM_READY) mem[MEM_ADDR] = MEM_WDATA;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    endtask

    task automatic start();
        RESET     = 1'b1;
        MEM_READY = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK);
    endtask

    // Architectural model: one instruction per iteration, cost 8 or 4 clocks.
    task automatic run_model();
        logic [15:0] w;
        logic [3:0]  op;
        logic [11:0] a;
        for (int i = 0; i < 4096; i++) ref_mem[i] = mem[i];
        ref_pc     = 12'h000;
        ref_ac     = 16'h0000;
        ref_clocks = 0;
        for (int s = 0; s < 1000; s++) begin
            w  = ref_mem[ref_pc];
            op = w[15:12];
            a  = w[11:0];
            ref_pc = ref_pc + 12'd1;
            ref_clocks += (op <= 4'd5) ? 8 : 4;
            case (op)
                4'h1: ref_ac = ref_mem[a];
                4'h2: ref_mem[a] = ref_ac;
                4'h3: ref_ac = ref_ac + ref_mem[a];
                4'h4: ref_ac = ref_ac - ref_mem[a];
                4'h5: ref_ac = ref_ac & ref_mem[a];
                4'h6: ref_pc = a;
                4'h7: if (ref_ac == 16'h0000) ref_pc = a;
                4'h8: if (ref_ac[15]) ref_pc = a;
                default: ;
            endcase
            if (op == 4'hF) break;
        end
    endtask

    task automatic run_to_halt(input bit rand_ready, output int unsigned clocks);
        clocks = 0;
        while (!HALTED && clocks < 3000) begin
            MEM_READY = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge CLK);
            clocks++;
        end
        MEM_READY = 1'b1;
        checks++;
        if (HALTED !== 1'b1) begin
            errors++;
            $display("FAIL halt_timeout: HALTED=%b after %0d clocks, required 1", HALTED, clocks);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        MEM_READY = 1'b1;
        step(2);
        checks++;
        if ({T3, T2, T1, T0} !== 4'b0001 || FETCH !== 1'b1 || EXECUTE !== 1'b0) begin
            errors++;
            $display("FAIL reset_phase: T3..T0=%b FETCH=%b, required 0001 1", {T3, T2, T1, T0}, FETCH);
        end
        checks++;
        if (PC_OUT !== 12'h000 || MA_OUT !== 12'h000 || MD_OUT !== 16'h0 || AC_OUT !== 16'h0 || IR_OUT !== 4'h0) begin
            errors++;
            $display("FAIL reset_regs: PC=%h MA=%h MD=%h AC=%h IR=%h, required all zero", PC_OUT, MA_OUT, MD_OUT, AC_OUT, IR_OUT);
        end
        checks++;
        if (HALTED !== 1'b0 || MEM_RD !== 1'b0 || MEM_WE !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: HALTED=%b RD=%b WE=%b, required 000", HALTED, MEM_RD, MEM_WE);
        end
    endtask

    task automatic test_halt();
        clear_mem();
        mem[0] = 16'hF000;
        start();
        for (int c = 0; c < 4; c++) begin
            checks++;
            if ({T3, T2, T1, T0} !== (4'b0001 << c) || FETCH !== 1'b1 || HALTED !== 1'b0) begin
                errors++;
                $display("FAIL halt_phase%0d: T3..T0=%b FETCH=%b HALTED=%b, required %b 1 0",
                         c, {T3, T2, T1, T0}, FETCH, HALTED, 4'b0001 << c);
            end
            if (c == 1) begin
                checks++;
                if (MEM_RD !== 1'b1) begin
                    errors++;
                    $display("FAIL halt_fetch_rd: MEM_RD=%b, required 1", MEM_RD);
                end
            end
            step(1);
        end
        for (int c = 4; c < 9; c++) begin
            checks++;
            if (HALTED !== 1'b1 || PC_OUT !== 12'h001 || T0 !== 1'b1 || FETCH !== 1'b1 || MEM_RD !== 1'b0 || MEM_WE !== 1'b0) begin
                errors++;
                $display("FAIL halt_frozen%0d: HALTED=%b PC=%h T0=%b FETCH=%b RD=%b WE=%b, required 1 001 1 1 0 0",
                         c, HALTED, PC_OUT, T0, FETCH, MEM_RD, MEM_WE);
            end
            step(1);
        end
    endtask

    task automatic test_program();
        int unsigned clocks;
        clear_mem();
        mem[12'h000] = 16'h1010;
        mem[12'h001] = 16'h3011;
        mem[12'h002] = 16'h2012;
        mem[12'h003] = 16'hF000;
        mem[12'h010] = 16'h0007;
        mem[12'h011] = 16'h0009;
        run_model();
        start();
        run_to_halt(1'b0, clocks);
        checks++;
        if (clocks !== 28 || clocks !== ref_clocks) begin
            errors++;
            $display("FAIL prog_clocks: got %0d, required 28 (model %0d)", clocks, ref_clocks);
        end
        checks++;
        if (mem[12'h012] !== 16'h0010 || AC_OUT !== 16'h0010) begin
            errors++;
            $display("FAIL prog_result: mem[012]=%h AC=%h, required 0010 0010", mem[12'h012], AC_OUT);
        end
    endtask

    task automatic test_sub_jn();
        int unsigned clocks;
        clear_mem();
        mem[12'h000] = 16'h1040;
        mem[12'h001] = 16'h4041;
        mem[12'h002] = 16'h8020;
        mem[12'h003] = 16'hF000;
        mem[12'h020] = 16'hF000;
        mem[12'h041] = 16'h0001;
        start();
        step(16);
        checks++;
        if (AC_OUT !== 16'hFFFF) begin
            errors++;
            $display("FAIL sub_underflow: AC=%h, required FFFF", AC_OUT);
        end
        step(4);
        checks++;
        if (PC_OUT !== 12'h020) begin
            errors++;
            $display("FAIL jn_taken: PC=%h, required 020", PC_OUT);
        end
        run_to_halt(1'b0, clocks);
        checks++;
        if (PC_OUT !== 12'h021) begin
            errors++;
            $display("FAIL jn_halt_pc: PC=%h, required 021", PC_OUT);
        end
    endtask

    task automatic test_jumps();
        clear_mem();
        mem[12'h000] = 16'h1040;
        mem[12'h001] = 16'h7030;
        mem[12'h002] = 16'h5041;
        mem[12'h003] = 16'h7050;
        mem[12'h050] = 16'h6FFF;
        mem[12'hFFF] = 16'hF000;
        mem[12'h040] = 16'h0003;
        start();
        step(12);
        checks++;
        if (PC_OUT !== 12'h002 || AC_OUT !== 16'h0003) begin
            errors++;
            $display("FAIL jz_not_taken: PC=%h AC=%h, required 002 0003", PC_OUT, AC_OUT);
        end
        step(12);
        checks++;
        if (PC_OUT !== 12'h050 || AC_OUT !== 16'h0000) begin
            errors++;
            $display("FAIL jz_taken: PC=%h AC=%h, required 050 0000", PC_OUT, AC_OUT);
        end
        step(4);
        checks++;
        if (PC_OUT !== 12'hFFF) begin
            errors++;
            $display("FAIL jmp: PC=%h, required FFF", PC_OUT);
        end
        step(4);
        checks++;
        if (PC_OUT !== 12'h000 || HALTED !== 1'b1) begin
            errors++;
            $display("FAIL pc_wrap: PC=%h HALTED=%b, required 000 1", PC_OUT, HALTED);
        end
    endtask

    task automatic test_wait();
        int rd_count = 0;
        clear_mem();
        mem[12'h000] = 16'h1010;
        mem[12'h001] = 16'hF000;
        mem[12'h010] = 16'h1234;
        start();
        for (int c = 0; c < 12; c++) begin
            if (c >= 5 && c <= 8 && MEM_RD === 1'b1) rd_count++;
            if (c == 8) begin
                checks++;
                if (T1 !== 1'b1 || EXECUTE !== 1'b1 || AC_OUT !== 16'h0000) begin
                    errors++;
                    $display("FAIL wait_hold: T1=%b EXECUTE=%b AC=%h, required 1 1 0000", T1, EXECUTE, AC_OUT);
                end
            end
            if (c == 11) begin
                checks++;
                if (T0 !== 1'b1 || FETCH !== 1'b1 || AC_OUT !== 16'h1234 || PC_OUT !== 12'h001) begin
                    errors++;
                    $display("FAIL wait_done: T0=%b FETCH=%b AC=%h PC=%h, required 1 1 1234 001", T0, FETCH, AC_OUT, PC_OUT);
                end
            end
            MEM_READY = (c >= 5 && c <= 7) ? 1'b0 : 1'b1;
            step(1);
        end
        checks++;
        if (rd_count != 4) begin
            errors++;
            $display("FAIL wait_rd_len: MEM_RD high %0d clocks, required 4", rd_count);
        end
    endtask

    task automatic test_reset_mid_sta();
        clear_mem();
        mem[12'h000] = 16'h1040;
        mem[12'h001] = 16'h2050;
        mem[12'h040] = 16'hABCD;
        mem[12'h050] = 16'h1111;
        start();
        step(13);
        checks++;
        if (MEM_WE !== 1'b1 || MEM_ADDR !== 12'h050 || MEM_WDATA !== 16'hABCD) begin
            errors++;
            $display("FAIL sta_t1: WE=%b ADDR=%h WDATA=%h, required 1 050 ABCD", MEM_WE, MEM_ADDR, MEM_WDATA);
        end
        #2 RESET = 1'b1;
        #1;
        checks++;
        if (MEM_WE !== 1'b0 || MEM_RD !== 1'b0) begin
            errors++;
            $display("FAIL async_strobe_drop: WE=%b RD=%b, required 0 0", MEM_WE, MEM_RD);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (mem[12'h050] !== 16'h1111) begin
            errors++;
            $display("FAIL aborted_write: mem[050]=%h, required 1111", mem[12'h050]);
        end
        checks++;
        if ({T3, T2, T1, T0} !== 4'b0001 || FETCH !== 1'b1 || PC_OUT !== 12'h000 || AC_OUT !== 16'h0 ||
            MA_OUT !== 12'h000 || MD_OUT !== 16'h0 || IR_OUT !== 4'h0 || HALTED !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_state: T=%b FETCH=%b PC=%h AC=%h MA=%h MD=%h IR=%h HALTED=%b, required reset values",
                     {T3, T2, T1, T0}, FETCH, PC_OUT, AC_OUT, MA_OUT, MD_OUT, IR_OUT, HALTED);
        end
    endtask

    task automatic test_random();
        int unsigned clocks;
        logic [3:0]  op;
        logic [11:0] opd;
        int          diffs;
        for (int r = 0; r < 6; r++) begin
            clear_mem();
            for (int i = 0; i < 12; i++) begin
                op = 4'($urandom_range(0, 14));
                if (op >= 4'h1 && op <= 4'h5)      opd = 12'h100 + 12'($urandom_range(0, 15));
                else if (op >= 4'h6 && op <= 4'h8) opd = 12'(i + 1 + int'($urandom_range(0, 11 - i)));
                else                               opd = 12'($urandom);
                mem[i] = {op, opd};
            end
            mem[12] = 16'hF000;
            for (int i = 0; i < 16; i++)
                mem[12'h100 + i] = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            run_model();
            start();
            run_to_halt(r >= 2, clocks);
            checks++;
            if (AC_OUT !== ref_ac || PC_OUT !== ref_pc) begin
                errors++;
                $display("FAIL rand%0d_regs: AC=%h PC=%h, required %h %h", r, AC_OUT, PC_OUT, ref_ac, ref_pc);
            end
            diffs = 0;
            for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) diffs++;
            checks++;
            if (diffs != 0) begin
                errors++;
                $display("FAIL rand%0d_mem: %0d words differ, required 0", r, diffs);
            end
            if (r < 2) begin
                checks++;
                if (clocks != ref_clocks) begin
                    errors++;
                    $display("FAIL rand%0d_clocks: got %0d, required %0d", r, clocks, ref_clocks);
                end
            end
        end
    endtask

    initial begin
        RESET     = 1'b1;
        MEM_READY = 1'b1;
        clear_mem();
        test_reset();
        test_halt();
        test_program();
        test_sub_jn();
        test_jumps();
        test_wait();
        test_reset_mid_sta();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dunc_core.md
# dunc_core

Parametrised successor to the dunc16 accumulator CPU. It is a single-accumulator machine sequenced by a four-phase T0–T3 generator and a FETCH/EXECUTE cycle flag, generalised in data and address width. Over the original LDA/STA core it adds arithmetic, logic, conditional jumps, halt, and a MEM_READY wait-state handshake to external memory. It is the processor node instantiated by the system top and its bench.

## Interface
- DATA_W, 16: accumulator/memory word width; must be ≥ ADDR_W+4
- ADDR_W, 12: address width; PC, MA and MEM_ADDR width
- RESET_PC, 0: PC value loaded on reset
- CLK in 1: single clock, all state on rising edge
- RESET in 1: asynchronous, active-high reset
- MEM_RDATA in DATA_W: read data, sampled on the edge that leaves T1 when MEM_READY=1
- MEM_READY in 1: access complete; low during T1 of an access inserts wait states
- MEM_ADDR out ADDR_W: equals MA_OUT
- MEM_WDATA out DATA_W: equals MD_OUT
- MEM_RD out 1: read strobe, high throughout T1 of a read access
- MEM_WE out 1: write strobe, high throughout T1 of a STA execute cycle
- T0, T1, T2, T3 out 1 each: one-hot phase
- FETCH, EXECUTE out 1 each: cycle flag and its complement
- PC_OUT out ADDR_W, MA_OUT out ADDR_W, MD_OUT out DATA_W, AC_OUT out DATA_W, IR_OUT out 4: register views
- HALTED out 1: high after HLT is executed

## Operation
- Instruction word: opcode = bits [DATA_W-1 -: 4]; operand address = bits [ADDR_W-1:0]; any bits in between are ignored.
- Opcodes:
  - 0 NOP, 1 LDA, 2 STA, 3 ADD, 4 SUB, 5 AND: memory class.
  - 6 JMP, 7 JZ, 8 JN: jumps.
  - F HLT.
  - 9–E decode as NOP.
- FETCH cycle:
  - T0: MA←PC.
  - T1: MEM_RD=1; MD←MEM_RDATA on exit.
  - T2: IR←opcode, MA←operand, PC←PC+1 (mod 2^ADDR_W).
  - T3, memory-class opcode: next cycle is EXECUTE.
  - T3, otherwise: execute in place and stay in FETCH. JMP: PC←MA. JZ: PC←MA if AC==0. JN: PC←MA if AC[DATA_W-1]. HLT: set HALTED. NOP: no change.
- EXECUTE cycle:
  - T0: STA loads MD←AC.
  - T1: STA drives MEM_WE=1; LDA/ADD/SUB/AND drive MEM_RD=1 and load MD←MEM_RDATA on exit.
  - T2: LDA AC←MD; ADD AC←AC+MD; SUB AC←AC−MD; AND AC←AC&MD. Arithmetic is mod 2^DATA_W, carry/borrow discarded.
  - T3: return to FETCH.
- Halted state: phase frozen at T0 with FETCH=1; no strobes asserted; all registers hold. Only RESET exits.
- Reset values:
  - PC=RESET_PC; AC, MA, MD, IR = 0.
  - T0=1, others 0; FETCH=1.
  - HALTED, MEM_RD, MEM_WE = 0.

## Timing
- Phase advances one per clock, T3 wraps to T0, except T1 of an access holds while MEM_READY=0.
- MEM_READY is ignored outside T1 and in T1 of non-access cycles.
- Zero-wait cost: non-memory instruction 4 clocks; memory-class instruction 8 clocks. Each wait cycle adds 1 clock.
- Strobes are decoded from registered state only: glitch-free, no combinational path from MEM_READY to MEM_RD/MEM_WE.
- Write commits on the edge leaving T1 with MEM_READY=1. Memory must hold MEM_ADDR/MEM_WDATA stable for the whole T1.
- PC wrap: PC=2^ADDR_W−1 increments to 0.
- RESET mid-access: strobes drop immediately (asynchronously); no write is attributed to the aborted cycle.
- JZ/JN test AC as it stands at T3, i.e. after any preceding instruction's T2 update.

## Structure
- Package dunc_pkg: opcode localparams (OP_NOP…OP_HLT), phase one-hot constants, is_mem_op(opcode) function.
- Sub-module dunc_tstate: 2-bit phase counter with stall input, one-hot T0–T3 outputs, async reset to T0, freeze input driven by HALTED.
- dunc_core holds the FETCH flag, PC/MA/MD/IR/AC, decode, and the ALU.

## Test plan
- Reset release, RESET_PC=0, mem[0]=F000, MEM_READY=1 → T0..T3 sequence seen once, PC_OUT=1, HALTED=1 at end of cycle 4, then frozen.
- Program LDA 10, ADD 11, STA 12, HLT with mem[10]=0007, mem[11]=0009 → mem[12]=0010, AC=0010, total 28 clocks to HALTED.
- SUB underflow: AC=0000, SUB of word 0001 → AC=FFFF; following JN 20 → PC=020.
- JZ not taken with AC=0003 → PC=next address; JZ taken with AC=0 → PC=operand; JMP 0FFF then fetch → PC wraps to 000.
- MEM_READY low for 3 cycles in a LDA execute T1 → MEM_RD high 4 clocks, AC loaded once, instruction takes 11 clocks.
- RESET asserted mid-STA T1 → MEM_WE falls without waiting for a clock edge, memory unchanged, all outputs at reset values.
